// File: rtl/dmux16_stream.sv
// Registered 1-to-2 stream demultiplexer: in_sel steers each word into
// a per-channel FIFO so a stalled consumer only blocks its own channel.
module dmux16_stream_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [7:0]       count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW:0]      occ_q, occ_d;
  logic [7:0]       cnt_q, cnt_d;

  assign full_o  = (occ_q == FULL_OCC);
  assign valid_o = (occ_q != '0);
  assign count_o = cnt_q;
  // Zero-gate the head so an empty channel presents all-zero data.
  assign data_o  = mem_q[rptr_q] & {WIDTH{valid_o}};

  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    occ_d  = occ_q;
    cnt_d  = cnt_q;
    if (push_i) wptr_d = wptr_q + 1'b1;
    if (pop_i) begin
      rptr_d = rptr_q + 1'b1;
      cnt_d  = cnt_q + 8'd1;
    end
    unique case ({push_i, pop_i})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_q <= '0;
      wptr_q <= '0;
      occ_q  <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      occ_q  <= occ_d;
      cnt_q  <= cnt_d;
      if (push_i) mem_q[wptr_q] <= data_i;
    end
  end

endmodule

module dmux16_stream #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [WIDTH-1:0] b_data,
  output logic [7:0]       a_count,
  output logic [7:0]       b_count
);

  logic full_a, full_b;
  logic push_a, push_b;
  logic pop_a, pop_b;
  logic acc;

  // Full-only readiness: a full FIFO refuses even while it pops.
  assign in_ready = in_sel ? !full_b : !full_a;
  assign acc      = in_valid && in_ready;
  assign push_a   = acc && !in_sel;
  assign push_b   = acc && in_sel;
  assign pop_a    = a_valid && a_ready;
  assign pop_b    = b_valid && b_ready;

  dmux16_stream_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push_a),
    .pop_i  (pop_a),
    .data_i (in_data),
    .full_o (full_a),
    .valid_o(a_valid),
    .data_o (a_data),
    .count_o(a_count)
  );

  dmux16_stream_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push_b),
    .pop_i  (pop_b),
    .data_i (in_data),
    .full_o (full_b),
    .valid_o(b_valid),
    .data_o (b_data),
    .count_o(b_count)
  );

endmodule

// File: tb/tb_dmux16_stream.sv
// Bench for dmux16_stream: directed vector table, hand sequences for
// count wrap and async reset, then random traffic against a queue model.
module tb_dmux16_stream;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        in_sel = 1'b0;
  logic        a_valid, b_valid;
  logic        a_ready = 1'b0, b_ready = 1'b0;
  logic [15:0] a_data, b_data;
  logic [7:0]  a_count, b_count;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmux16_stream #(
    .WIDTH(16),
    .DEPTH(DEPTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data (in_data),
    .in_sel  (in_sel),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .a_data  (a_data),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .b_data  (b_data),
    .a_count (a_count),
    .b_count (b_count)
  );

  typedef struct {
    logic        iv;
    logic        sel;
    logic [15:0] d;
    logic        ar;
    logic        br;
    logic        ir;
    logic        av;
    logic [15:0] ad;
    logic        bv;
    logic [15:0] bd;
    logic [7:0]  ac;
    logic [7:0]  bc;
  } vec_t;

  vec_t vt [16];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(logic iv, logic sel, logic [15:0] d,
                       logic ar, logic br);
    in_valid = iv;
    in_sel   = sel;
    in_data  = d;
    a_ready  = ar;
    b_ready  = br;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  task automatic chk_state(string tag, logic av, logic [15:0] ad,
                           logic bv, logic [15:0] bd,
                           logic [7:0] ac, logic [7:0] bc);
    chk({tag, ".a_valid"}, a_valid, av);
    chk({tag, ".a_data"},  a_data,  ad);
    chk({tag, ".b_valid"}, b_valid, bv);
    chk({tag, ".b_data"},  b_data,  bd);
    chk({tag, ".a_count"}, a_count, ac);
    chk({tag, ".b_count"}, b_count, bc);
  endtask

  logic [15:0] qa[$], qb[$];
  int          ca, cb;

  initial begin
    vt[0]  = '{1'b1, 1'b0, 16'h1234, 1'b1, 1'b1, 1'b1,
               1'b1, 16'h1234, 1'b0, 16'h0000, 8'd0, 8'd0};
    vt[1]  = '{1'b1, 1'b1, 16'h9876, 1'b1, 1'b1, 1'b1,
               1'b0, 16'h0000, 1'b1, 16'h9876, 8'd1, 8'd0};
    vt[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1,
               1'b0, 16'h0000, 1'b0, 16'h0000, 8'd1, 8'd1};
    vt[3]  = '{1'b1, 1'b0, 16'hAAAA, 1'b0, 1'b1, 1'b1,
               1'b1, 16'hAAAA, 1'b0, 16'h0000, 8'd1, 8'd1};
    vt[4]  = '{1'b1, 1'b0, 16'h5555, 1'b0, 1'b1, 1'b1,
               1'b1, 16'hAAAA, 1'b0, 16'h0000, 8'd1, 8'd1};
    vt[5]  = '{1'b1, 1'b0, 16'h7777, 1'b0, 1'b1, 1'b0,
               1'b1, 16'hAAAA, 1'b0, 16'h0000, 8'd1, 8'd1};
    vt[6]  = '{1'b1, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b1,
               1'b1, 16'hAAAA, 1'b1, 16'h0001, 8'd1, 8'd1};
    vt[7]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0,
               1'b1, 16'hAAAA, 1'b0, 16'h0000, 8'd1, 8'd2};
    vt[8]  = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1,
               1'b1, 16'h5555, 1'b0, 16'h0000, 8'd2, 8'd2};
    vt[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1,
               1'b0, 16'h0000, 1'b0, 16'h0000, 8'd3, 8'd2};
    vt[10] = '{1'b1, 1'b0, 16'hBBBB, 1'b0, 1'b1, 1'b1,
               1'b1, 16'hBBBB, 1'b0, 16'h0000, 8'd3, 8'd2};
    vt[11] = '{1'b1, 1'b0, 16'hCCCC, 1'b0, 1'b1, 1'b1,
               1'b1, 16'hBBBB, 1'b0, 16'h0000, 8'd3, 8'd2};
    vt[12] = '{1'b1, 1'b0, 16'hDDDD, 1'b1, 1'b1, 1'b0,
               1'b1, 16'hCCCC, 1'b0, 16'h0000, 8'd4, 8'd2};
    vt[13] = '{1'b1, 1'b0, 16'hDDDD, 1'b0, 1'b1, 1'b1,
               1'b1, 16'hCCCC, 1'b0, 16'h0000, 8'd4, 8'd2};
    vt[14] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0,
               1'b1, 16'hDDDD, 1'b0, 16'h0000, 8'd5, 8'd2};
    vt[15] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1,
               1'b0, 16'h0000, 1'b0, 16'h0000, 8'd6, 8'd2};

    // Reset state
    do_reset();
    chk_state("rst", 1'b0, 16'h0, 1'b0, 16'h0, 8'd0, 8'd0);
    in_sel = 1'b0; #1 chk("rst.in_ready_a", in_ready, 1'b1);
    in_sel = 1'b1; #1 chk("rst.in_ready_b", in_ready, 1'b1);

    // Directed table
    for (int i = 0; i < 16; i++) begin
      drive(vt[i].iv, vt[i].sel, vt[i].d, vt[i].ar, vt[i].br);
      #1 chk($sformatf("vec%0d.in_ready", i), in_ready, vt[i].ir);
      @(posedge clk);
      #1;
      chk_state($sformatf("vec%0d", i), vt[i].av, vt[i].ad,
                vt[i].bv, vt[i].bd, vt[i].ac, vt[i].bc);
    end

    // Count wrap: 257 words to b, each popped the cycle after accept
    do_reset();
    for (int k = 0; k < 257; k++) begin
      drive(1'b1, 1'b1, 16'(k + 16'h100), 1'b0, 1'b1);
      #1 chk($sformatf("wrap%0d.in_ready", k), in_ready, 1'b1);
      @(posedge clk);
      #1 chk($sformatf("wrap%0d.b_data", k), b_data, 16'(k + 16'h100));
    end
    drive(1'b0, 1'b1, 16'h0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk_state("wrap.end", 1'b0, 16'h0, 1'b0, 16'h0, 8'd0, 8'd1);

    // Async reset with both FIFOs holding words and nonzero counts
    drive(1'b1, 1'b0, 16'h1111, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 16'h2222, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 16'h3333, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk_state("pre_arst", 1'b1, 16'h2222, 1'b1, 16'h3333, 8'd1, 8'd1);
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_state("arst", 1'b0, 16'h0, 1'b0, 16'h0, 8'd0, 8'd0);
    chk("arst.in_ready_a", in_ready, 1'b1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 16'h4444, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_state("post_arst", 1'b1, 16'h4444, 1'b0, 16'h0, 8'd0, 8'd0);

    // Random traffic against a queue model
    do_reset();
    qa.delete(); qb.delete();
    ca = 0; cb = 0;
    for (int c = 0; c < 3000; c++) begin
      logic iv, sel, ar, br, eir, pa, pb;
      logic [15:0] d;
      iv  = 1'($urandom_range(0, 1));
      sel = 1'($urandom_range(0, 1));
      ar  = ($urandom_range(0, 3) != 0);
      br  = ($urandom_range(0, 2) == 0);
      d   = 16'($urandom);
      drive(iv, sel, d, ar, br);
      #1;
      eir = sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
      chk($sformatf("rnd%0d.in_ready", c), in_ready, eir);
      chk_state($sformatf("rnd%0d", c),
                qa.size() != 0, (qa.size() != 0) ? qa[0] : 16'h0,
                qb.size() != 0, (qb.size() != 0) ? qb[0] : 16'h0,
                8'(ca % 256), 8'(cb % 256));
      pa = ar && (qa.size() != 0);
      pb = br && (qb.size() != 0);
      @(posedge clk);
      if (pa) begin void'(qa.pop_front()); ca++; end
      if (pb) begin void'(qb.pop_front()); cb++; end
      if (iv && eir) begin
        if (sel) qb.push_back(d);
        else     qa.push_back(d);
      end
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
